// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, total-period helpers and the sync bundle
// carried by the monitor-side delay line.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned CNT_MAX = 1 << CNT_W;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_t;

  // Sync pulses idle high, DAC blanked.
  localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// DEPTH-stage delay line for the monitor-side sync bundle; DEPTH=0 is a plain wire.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic  vga_clk,
  input  logic  reset,
  input  sync_t i_sync,
  output sync_t o_sync
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign o_sync = i_sync;
    end else begin : g_pipe
      sync_t [DEPTH-1:0] r_pipe;

      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= SYNC_RST;
        end else begin
          r_pipe[0] <= i_sync;
          for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_sync = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters, renderer-side DrawX/DrawY/blank,
// and delay-matched monitor sync. Define VGA_FRAME_CNT_EN to add the frame_count output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned PIPE_LAG  = 1
) (
  input  logic             vga_clk,
  input  logic             reset,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  output logic             blank,
  output logic             line_start,
  output logic             frame_start,
  output logic             hs,
  output logic             vs,
  output logic             dac_blank_n
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam int unsigned HS_BEG = H_VISIBLE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_VISIBLE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;

  generate
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX || PIPE_LAG > 4) begin : g_bad_cfg
      $error("vga_timing_gen: totals must be <= 1024 and PIPE_LAG in 0..4");
    end
  endgenerate

  logic [CNT_W-1:0] r_hc, r_vc;
  sync_t            w_sync_nxt, r_sync, w_sync_dly;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (r_hc == H_LAST) begin
      r_hc <= '0;
      r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
    end else begin
      r_hc <= r_hc + 1'b1;
    end
  end

  always_comb begin
    w_sync_nxt.hs      = !(int'(r_hc) >= HS_BEG && int'(r_hc) < HS_END);
    w_sync_nxt.vs      = !(int'(r_vc) >= VS_BEG && int'(r_vc) < VS_END);
    w_sync_nxt.blank_n = (int'(r_hc) < H_VISIBLE) && (int'(r_vc) < V_VISIBLE);
  end

  // Every output is a flop off the counters, so the raster lags hc/vc by one cycle.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      blank       <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      r_sync      <= SYNC_RST;
    end else begin
      DrawX       <= r_hc;
      DrawY       <= r_vc;
      blank       <= w_sync_nxt.blank_n;
      line_start  <= (r_hc == '0);
      frame_start <= (r_hc == '0) && (r_vc == '0);
      r_sync      <= w_sync_nxt;
    end
  end

  vga_sync_delay #(.DEPTH(PIPE_LAG)) u_sync_delay (
    .vga_clk (vga_clk),
    .reset   (reset),
    .i_sync  (r_sync),
    .o_sync  (w_sync_dly)
  );

  assign hs          = w_sync_dly.hs;
  assign vs          = w_sync_dly.vs;
  assign dac_blank_n = w_sync_dly.blank_n;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Bump on the edge that takes DrawX/DrawY from the last pixel back to 0/0.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset)                                r_frame_cnt <= '0;
    else if (DrawX == H_LAST && DrawY == V_LAST) r_frame_cnt <= r_frame_cnt + 1'b1;
  end

  assign frame_count = r_frame_cnt;
`endif

endmodule
